// File: rtl/enemy_spawn_selector.sv
// enemy_spawn_selector
// Picks one of NUM_SLOTS enemy ROM start addresses per rising edge of flip.
// Modes: cyclic, LFSR random, random without immediate repeat, fixed slot.
// The result is offered on a valid/ack handshake. One extra request can wait
// while a pick is in progress; any request beyond that is reported on dropped.
module enemy_spawn_selector #(
    parameter int          ADRESSWIDTH = 10,
    parameter int          NUM_SLOTS   = 4,
    parameter int          ADR_BASE    = 0,
    parameter int          SLOT_STRIDE = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          MAX_TRIES   = 8,
    localparam int         IDXW        = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flip,
    input  logic [1:0]             mode,
    input  logic [IDXW-1:0]        fixed_slot,
    input  logic                   ack,
    output logic [ADRESSWIDTH-1:0] adr_enemy_random,
    output logic [IDXW-1:0]        slot_idx,
    output logic                   adr_valid,
    output logic                   busy,
    output logic                   dropped
);

    // Width of the rejection counter: it has to hold MAX_TRIES itself.
    localparam int TRYW = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;

    // One bit wider than an index so NUM_SLOTS = 2^IDXW is representable.
    localparam logic [IDXW:0]            NUM_SLOTS_W = (IDXW + 1)'(NUM_SLOTS);
    localparam logic [IDXW-1:0]          LAST_IDX    = IDXW'(NUM_SLOTS - 1);
    localparam logic [TRYW-1:0]          MAX_TRIES_W = TRYW'(MAX_TRIES);
    localparam logic [15:0]              LFSR_MASK   = 16'hB400;
    // An all-zero Galois LFSR never leaves zero, so a zero seed becomes 1.
    localparam logic [15:0]              LFSR_INIT   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [ADRESSWIDTH-1:0]   ADR_RESET   = ADRESSWIDTH'(ADR_BASE);
    // With a single slot the no-repeat rule could never be satisfied.
    localparam bit                       NO_REPEAT   = (NUM_SLOTS > 1);

    localparam logic [1:0] MODE_CYCLIC = 2'b00;
    localparam logic [1:0] MODE_FIXED  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PICK  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    // Address of a slot, reduced modulo 2^ADRESSWIDTH. Working in the address
    // width keeps exactly the low bits the wrap-around definition asks for.
    function automatic logic [ADRESSWIDTH-1:0] slot_addr(input logic [IDXW-1:0] idx);
        logic [ADRESSWIDTH-1:0] base_w;
        logic [ADRESSWIDTH-1:0] stride_w;
        logic [ADRESSWIDTH-1:0] idx_w;
        base_w   = ADRESSWIDTH'(ADR_BASE);
        stride_w = ADRESSWIDTH'(SLOT_STRIDE);
        idx_w    = ADRESSWIDTH'(idx);
        return base_w + idx_w * stride_w;
    endfunction

    // Next slot in cyclic order, wrapping NUM_SLOTS-1 back to 0.
    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] x);
        return (x == LAST_IDX) ? '0 : x + IDXW'(1);
    endfunction

    state_t                   state_q,    state_d;
    logic                     flip_q,     flip_d;
    logic [1:0]               mode_q,     mode_d;
    logic [IDXW-1:0]          cnt_q,      cnt_d;
    logic [IDXW-1:0]          last_q,     last_d;
    logic                     has_last_q, has_last_d;
    logic                     pending_q,  pending_d;
    logic [15:0]              lfsr_q,     lfsr_d;
    logic [TRYW-1:0]          tries_q,    tries_d;
    logic [IDXW-1:0]          slot_q,     slot_d;
    logic [ADRESSWIDTH-1:0]   adr_q,      adr_d;
    logic                     valid_q,    valid_d;
    logic                     dropped_q,  dropped_d;

    logic                     req;
    logic                     pick_accept;
    logic [IDXW-1:0]          pick_idx;
    logic [IDXW-1:0]          pick_cnt_next;
    logic [IDXW-1:0]          cand;
    logic [IDXW-1:0]          fixed_clamped;
    logic                     cand_reject;
    logic                     use_fallback;

    // A flip level held high yields only the cycle of its rising edge.
    assign req = flip & ~flip_q;

    // Evaluate the candidate for the current PICK cycle under the latched mode.
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; a missing default would infer a latch.
    always_comb begin
        cand          = lfsr_q[IDXW-1:0];
        pick_idx      = cnt_q;
        pick_cnt_next = cnt_q;
        pick_accept   = 1'b0;
        cand_reject   = 1'b0;
        use_fallback  = (tries_q == MAX_TRIES_W);
        fixed_clamped = ({1'b0, fixed_slot} >= NUM_SLOTS_W) ? LAST_IDX : fixed_slot;

        case (mode_q)
            MODE_CYCLIC: begin
                pick_idx      = cnt_q;
                pick_cnt_next = wrap_inc(cnt_q);
                pick_accept   = 1'b1;
            end
            MODE_FIXED: begin
                pick_idx    = fixed_clamped;
                pick_accept = 1'b1;
            end
            default: begin
                // Random modes; mode_q[1] set means no immediate repeat.
                cand_reject = ({1'b0, cand} >= NUM_SLOTS_W) ||
                              (mode_q[1] && NO_REPEAT && has_last_q && (cand == last_q));
                if (use_fallback) begin
                    // Out of tries: take the cyclic counter, stepping past
                    // the last slot when a repeat is not allowed.
                    pick_idx = cnt_q;
                    if (mode_q[1] && NO_REPEAT && has_last_q && (cnt_q == last_q)) begin
                        pick_idx = wrap_inc(cnt_q);
                    end
                    pick_cnt_next = wrap_inc(pick_idx);
                    pick_accept   = 1'b1;
                end else if (!cand_reject) begin
                    pick_idx    = cand;
                    pick_accept = 1'b1;
                end
            end
        endcase
    end

    // Next-state logic for the request FSM, the pending slot and the LFSR.
    always_comb begin
        state_d    = state_q;
        flip_d     = flip;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        has_last_d = has_last_q;
        pending_d  = pending_q;
        tries_d    = tries_q;
        slot_d     = slot_q;
        adr_d      = adr_q;
        valid_d    = valid_q;
        dropped_d  = 1'b0;
        // Galois step every cycle, independent of the FSM.
        lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_PICK;
                    mode_d  = mode;
                    tries_d = '0;
                end
            end

            S_PICK: begin
                if (req) begin
                    if (pending_q) begin
                        dropped_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
                if (pick_accept) begin
                    slot_d     = pick_idx;
                    adr_d      = slot_addr(pick_idx);
                    valid_d    = 1'b1;
                    last_d     = pick_idx;
                    has_last_d = 1'b1;
                    cnt_d      = pick_cnt_next;
                    state_d    = S_VALID;
                end else begin
                    tries_d = tries_q + TRYW'(1);
                end
            end

            S_VALID: begin
                if (ack) begin
                    valid_d = 1'b0;
                    if (pending_q || req) begin
                        // A request arriving with the ack is served at once.
                        state_d   = S_PICK;
                        mode_d    = mode;
                        tries_d   = '0;
                        pending_d = 1'b0;
                        if (pending_q && req) begin
                            dropped_d = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (req) begin
                    if (pending_q) begin
                        dropped_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            flip_q     <= 1'b0;
            mode_q     <= MODE_CYCLIC;
            cnt_q      <= '0;
            last_q     <= '0;
            has_last_q <= 1'b0;
            pending_q  <= 1'b0;
            lfsr_q     <= LFSR_INIT;
            tries_q    <= '0;
            slot_q     <= '0;
            adr_q      <= ADR_RESET;
            valid_q    <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            flip_q     <= flip_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            has_last_q <= has_last_d;
            pending_q  <= pending_d;
            lfsr_q     <= lfsr_d;
            tries_q    <= tries_d;
            slot_q     <= slot_d;
            adr_q      <= adr_d;
            valid_q    <= valid_d;
            dropped_q  <= dropped_d;
        end
    end

    assign adr_enemy_random = adr_q;
    assign slot_idx         = slot_q;
    assign adr_valid        = valid_q;
    assign busy             = (state_q != S_IDLE);
    assign dropped          = dropped_q;

endmodule

// File: tb/tb_enemy_spawn_selector.sv
// Scoreboard bench for enemy_spawn_selector: a 4-slot instance covers the
// cyclic, fixed, buffering and reset scenarios; a 3-slot instance covers the
// no-repeat random mode and fixed-slot clamping.
module tb_enemy_spawn_selector;

    localparam int          AW        = 10;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          MAX_TRIES = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    slot;
        int            exp_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          flip4 = 1'b0, ack4 = 1'b0;
    logic [1:0]    mode4 = 2'b00, fixed4 = 2'b00;
    logic [AW-1:0] adr4;
    logic [1:0]    slot4;
    logic          valid4, busy4, dropped4;

    logic          flip3 = 1'b0, ack3 = 1'b0;
    logic [1:0]    mode3 = 2'b00, fixed3 = 2'b00;
    logic [AW-1:0] adr3;
    logic [1:0]    slot3;
    logic          valid3, busy3, dropped3;

    enemy_spawn_selector #(
        .ADRESSWIDTH(AW), .NUM_SLOTS(4), .ADR_BASE(0), .SLOT_STRIDE(64),
        .LFSR_SEED(SEED), .MAX_TRIES(MAX_TRIES)
    ) u_dut4 (
        .clk(clk), .rst(rst), .flip(flip4), .mode(mode4), .fixed_slot(fixed4),
        .ack(ack4), .adr_enemy_random(adr4), .slot_idx(slot4),
        .adr_valid(valid4), .busy(busy4), .dropped(dropped4)
    );

    enemy_spawn_selector #(
        .ADRESSWIDTH(AW), .NUM_SLOTS(3), .ADR_BASE(0), .SLOT_STRIDE(64),
        .LFSR_SEED(SEED), .MAX_TRIES(MAX_TRIES)
    ) u_dut3 (
        .clk(clk), .rst(rst), .flip(flip3), .mode(mode3), .fixed_slot(fixed3),
        .ack(ack3), .adr_enemy_random(adr3), .slot_idx(slot3),
        .adr_valid(valid3), .busy(busy3), .dropped(dropped3)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    exp_t q4[$];
    exp_t q3[$];

    // Bench model of the LFSR, shared by both instances (same seed, same reset).
    logic [15:0] m_lfsr;
    // Model state of the 3-slot instance for the random mode.
    logic [1:0]  m3_cnt      = 2'd0;
    logic [1:0]  m3_last     = 2'd0;
    bit          m3_has_last = 1'b0;

    bit          in_t4       = 1'b0;
    bit          have_prev3  = 1'b0;
    logic [1:0]  prev_slot3  = 2'd0;
    logic [2:0]  seen3       = 3'b000;
    logic        prev_v4     = 1'b0;
    logic        prev_v3     = 1'b0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_lfsr <= rst ? SEED : lfsr_step(m_lfsr);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 4-slot instance: every new adr_valid pops one expectation.
    always @(negedge clk) begin
        if (valid4 && !prev_v4) begin
            if (q4.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut4_unexpected: got slot %0d addr %0d, expected no output", slot4, adr4);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("dut4_addr", int'(adr4), int'(e.addr));
                check("dut4_slot", int'(slot4), int'(e.slot));
                check("dut4_latency", cyc, e.exp_cyc);
            end
        end
        prev_v4 <= valid4;
    end

    // Monitor for the 3-slot instance, with the no-repeat properties on top.
    always @(negedge clk) begin
        if (valid3 && !prev_v3) begin
            if (q3.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut3_unexpected: got slot %0d addr %0d, expected no output", slot3, adr3);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("dut3_addr", int'(adr3), int'(e.addr));
                check("dut3_slot", int'(slot3), int'(e.slot));
                check("dut3_latency", cyc, e.exp_cyc);
            end
            if (in_t4) begin
                check("t4_range", int'(slot3 < 2'd3), 1);
                if (have_prev3) check("t4_norepeat", int'(slot3 != prev_slot3), 1);
                if (slot3 < 2'd3) seen3[slot3] = 1'b1;
                prev_slot3 = slot3;
                have_prev3 = 1'b1;
            end
        end
        prev_v3 <= valid3;
    end

    task automatic wait_valid4();
        int n = 0;
        while (!valid4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!valid4) check("dut4_timeout", 0, 1);
    endtask

    task automatic wait_valid3();
        int n = 0;
        while (!valid3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!valid3) check("dut3_timeout", 0, 1);
    endtask

    task automatic ack4_pulse();
        ack4 = 1'b1;
        @(negedge clk);
        ack4 = 1'b0;
    endtask

    // One flip pulse on the 4-slot instance, expected first-try accept, acked.
    task automatic req4(input logic [AW-1:0] a, input logic [1:0] s);
        @(negedge clk);
        q4.push_back('{a, s, cyc + 2});
        flip4 = 1'b1;
        @(negedge clk);
        flip4 = 1'b0;
        wait_valid4();
        ack4_pulse();
    endtask

    // One no-repeat random request on the 3-slot instance, predicted by the model.
    task automatic req3_random();
        logic [15:0] l;
        logic [1:0]  idx;
        logic [1:0]  c;
        int          k;
        bit          done;
        @(negedge clk);
        l    = m_lfsr;
        k    = 0;
        done = 1'b0;
        idx  = 2'd0;
        while (!done) begin
            l = lfsr_step(l);
            c = l[1:0];
            if (k == MAX_TRIES) begin
                idx = m3_cnt;
                if (m3_has_last && idx == m3_last) idx = inc3(idx);
                m3_cnt = inc3(idx);
                done   = 1'b1;
            end else if (c != 2'd3 && !(m3_has_last && c == m3_last)) begin
                idx  = c;
                done = 1'b1;
            end else begin
                k++;
            end
        end
        m3_last     = idx;
        m3_has_last = 1'b1;
        q3.push_back('{AW'(int'(idx) * 64), idx, cyc + 2 + k});
        flip3 = 1'b1;
        @(negedge clk);
        flip3 = 1'b0;
        wait_valid3();
        ack3 = 1'b1;
        @(negedge clk);
        ack3 = 1'b0;
    endtask

    task automatic check_reset4(input string tag);
        check({tag, "_adr"}, int'(adr4), 0);
        check({tag, "_slot"}, int'(slot4), 0);
        check({tag, "_valid"}, int'(valid4), 0);
        check({tag, "_busy"}, int'(busy4), 0);
        check({tag, "_dropped"}, int'(dropped4), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int c0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset4("reset");
        check("reset_valid3", int'(valid3), 0);
        rst = 1'b0;

        // Test 1: cyclic mode, five acked pulses.
        mode4 = 2'b00;
        req4(10'd0, 2'd0);
        req4(10'd64, 2'd1);
        req4(10'd128, 2'd2);
        req4(10'd192, 2'd3);
        req4(10'd0, 2'd0);

        // Test 2: flip held high for 10 cycles gives a single request.
        apply_reset();
        @(negedge clk);
        q4.push_back('{10'd0, 2'd0, cyc + 2});
        flip4 = 1'b1;
        repeat (10) @(negedge clk);
        flip4 = 1'b0;
        ack4_pulse();
        repeat (6) @(negedge clk);
        check("t2_busy", int'(busy4), 0);

        // Test 3: pending request and a dropped third request.
        apply_reset();
        @(negedge clk);
        c0 = cyc;
        q4.push_back('{10'd0, 2'd0, c0 + 2});
        flip4 = 1'b1;
        @(negedge clk); flip4 = 1'b0;
        @(negedge clk); flip4 = 1'b1;
        @(negedge clk); flip4 = 1'b0;
        @(negedge clk); flip4 = 1'b1;
        @(negedge clk); flip4 = 1'b0;
        check("t3_dropped_pulse", int'(dropped4), 1);
        @(negedge clk);
        check("t3_dropped_clear", int'(dropped4), 0);
        check("t3_valid_held", int'(valid4), 1);
        q4.push_back('{10'd64, 2'd1, cyc + 2});
        ack4_pulse();
        check("t3_valid_after_ack", int'(valid4), 0);
        check("t3_busy_after_ack", int'(busy4), 1);
        wait_valid4();
        ack4_pulse();
        repeat (4) @(negedge clk);
        check("t3_busy_end", int'(busy4), 0);

        // Test 5: fixed slot (7 truncated to the 2-bit port is 3), mode
        // changed to cyclic while the pick is in progress.
        @(negedge clk);
        mode4  = 2'b11;
        fixed4 = 2'd3;
        q4.push_back('{10'd192, 2'd3, cyc + 2});
        flip4 = 1'b1;
        @(negedge clk);
        flip4 = 1'b0;
        mode4 = 2'b00;
        wait_valid4();
        ack4_pulse();
        @(negedge clk);
        check("t5_hold_adr", int'(adr4), 192);
        check("t5_hold_slot", int'(slot4), 3);
        check("t5_hold_valid", int'(valid4), 0);
        // ack with nothing valid must not disturb anything.
        ack4_pulse();
        check("t5_idle_ack_adr", int'(adr4), 192);
        check("t5_idle_ack_busy", int'(busy4), 0);

        // Test 6: reset while valid with a pending request.
        @(negedge clk);
        q4.push_back('{10'd128, 2'd2, cyc + 2});
        flip4 = 1'b1;
        @(negedge clk);
        flip4 = 1'b0;
        wait_valid4();
        flip4 = 1'b1;
        @(negedge clk);
        flip4 = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check_reset4("t6_reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_pending_lost", int'(busy4), 0);
        req4(10'd0, 2'd0);

        // Test 4: no-repeat random mode on the 3-slot instance.
        mode3 = 2'b10;
        in_t4 = 1'b1;
        for (int i = 0; i < 200; i++) req3_random();
        in_t4 = 1'b0;
        check("t4_all_slots_seen", int'(seen3), 7);

        // Fixed slot beyond the last slot is clamped to slot 2.
        @(negedge clk);
        mode3  = 2'b11;
        fixed3 = 2'd3;
        q3.push_back('{10'd128, 2'd2, cyc + 2});
        flip3 = 1'b1;
        @(negedge clk);
        flip3 = 1'b0;
        wait_valid3();
        ack3 = 1'b1;
        @(negedge clk);
        ack3 = 1'b0;

        repeat (4) @(negedge clk);
        check("dut4_queue_empty", q4.size(), 0);
        check("dut3_queue_empty", q3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
